// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a
// valid/ready byte handshake with framing-error and overrun pulses.
module uart_rx #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RXD,
  output logic [7:0] DATA,
  output logic       VALID,
  input  logic       READY,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
  output logic       BUSY
);

  localparam int N  = CLK_FREQ_HZ / BAUD_RATE;
  localparam int H  = N / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (N < 4) begin : g_bad_rate
    $error("uart_rx: CLK_FREQ_HZ / BAUD_RATE must be at least 4");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t          state_r, state_s;
  logic [1:0]      sync_r;
  logic            rx_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [2:0]      bit_idx_r, bit_idx_s;
  logic [7:0]      shift_r, shift_s;
  logic            done_s;
  logic            ferr_s;

  assign rx_s = sync_r[1];

  // Synchroniser, FSM state and datapath registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_r    <= 2'b11;
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
    end else begin
      sync_r    <= {sync_r[0], RXD};
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_idx_r <= bit_idx_s;
      shift_r   <= shift_s;
    end
  end

  // Next-state logic: bit timing, sampling and frame completion
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    bit_idx_s = bit_idx_r;
    shift_s   = shift_r;
    done_s    = 1'b0;
    ferr_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rx_s) begin
          state_s = ST_START;
          cnt_s   = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        // Half a bit in: a line that has gone high again was a glitch
        if (cnt_r == CW'(H - 1)) begin
          cnt_s = '0;
          if (rx_s) begin
            state_s = ST_IDLE;
          end else begin
            state_s   = ST_DATA;
            bit_idx_s = 3'd0;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_r == CW'(N - 1)) begin
          cnt_s     = '0;
          shift_s   = {rx_s, shift_r[7:1]};
          bit_idx_s = bit_idx_r + 3'd1;
          if (bit_idx_r == 3'd7) begin
            state_s = ST_STOP;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_STOP: begin
        // Leave at mid stop bit so the next start edge has no dead time
        if (cnt_r == CW'(N - 1)) begin
          cnt_s = '0;
          if (rx_s) begin
            done_s  = 1'b1;
            state_s = ST_IDLE;
          end else begin
            ferr_s  = 1'b1;
            state_s = ST_BREAK;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BREAK;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // Output handshake, error pulses and busy flag
  always_ff @(posedge CLK) begin
    if (RESET) begin
      DATA      <= 8'h00;
      VALID     <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      FRAME_ERR <= ferr_s;
      OVERRUN   <= 1'b0;
      BUSY      <= (state_r != ST_IDLE);
      if (done_s) begin
        // A byte accepted on this same edge frees the slot for the new one
        if (!VALID || READY) begin
          DATA  <= shift_r;
          VALID <= 1'b1;
        end else begin
          OVERRUN <= 1'b1;
        end
      end else if (VALID && READY) begin
        VALID <= 1'b0;
      end else begin
        VALID <= VALID;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at N=16, H=8: stimulus pushes expected bytes
// and flag events, a negedge monitor pops and compares them.
module tb_uart_rx;

  localparam int N = 16;
  localparam int H = 8;

  logic       clk;
  logic       reset;
  logic       rxd;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t0 = 0;
  int val_cyc = 0;
  int ferr_cyc = 0;
  int ovr_cyc = 0;
  logic pv = 1'b0;
  logic pr = 1'b0;

  logic [7:0] exp_byte_q[$];
  int         exp_flag_q[$];   // 1 = frame error, 2 = overrun

  uart_rx #(.CLK_FREQ_HZ(16), .BAUD_RATE(1)) dut (
    .CLK(clk), .RESET(reset), .RXD(rxd), .DATA(data), .VALID(valid),
    .READY(ready), .FRAME_ERR(frame_err), .OVERRUN(overrun), .BUSY(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start bit, 8 data bits LSB first, stop bit; the line is left at the stop level
  task automatic send(input logic [7:0] d, input logic stop_bit);
    t0 = cyc + 1;
    rxd = 1'b0;
    wait_cyc(N);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      wait_cyc(N);
    end
    rxd = stop_bit;
    wait_cyc(N);
  endtask

  // Monitor: compare each newly presented byte and each flag pulse
  always @(negedge clk) begin
    if (reset) begin
      pv <= 1'b0;
      pr <= 1'b0;
    end else begin
      if (valid && (!pv || pr)) begin
        val_cyc <= cyc;
        if (exp_byte_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_byte: got %0h expected none (cycle %0d)", data, cyc);
        end else begin
          chk("byte", data, exp_byte_q.pop_front());
        end
      end
      if (frame_err && overrun) begin
        n_cmp++;
        n_bad++;
        $display("FAIL both_flags: got FRAME_ERR=1 OVERRUN=1 expected at most one (cycle %0d)", cyc);
      end
      if (frame_err || overrun) begin
        if (frame_err) ferr_cyc <= cyc;
        if (overrun) ovr_cyc <= cyc;
        if (exp_flag_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_flag: got ferr=%0b ovr=%0b expected none (cycle %0d)",
                   frame_err, overrun, cyc);
        end else begin
          chk("flag_kind", frame_err ? 32'd1 : 32'd2, exp_flag_q.pop_front());
        end
      end
      pv <= valid;
      pr <= ready;
    end
  end

  initial begin
    int rise_seen;
    reset = 1'b1;
    rxd   = 1'b1;
    ready = 1'b0;
    wait_cyc(3);
    @(negedge clk);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_cyc(4);

    // 0x55 with READY low, then a one-cycle READY pulse
    exp_byte_q.push_back(8'h55);
    send(8'h55, 1'b1);
    rxd = 1'b1;
    wait_cyc(2);
    @(negedge clk);
    chk("lat_55", val_cyc - t0, 154);
    chk("valid_55", valid, 1'b1);
    chk("data_55", data, 8'h55);
    @(posedge clk); #1;
    ready = 1'b1;
    wait_cyc(1);
    ready = 1'b0;
    @(negedge clk);
    chk("valid_clr", valid, 1'b0);
    wait_cyc(4);

    // False start: low for 4 cycles only
    rxd = 1'b0;
    wait_cyc(4);
    rxd = 1'b1;
    rise_seen = 0;
    for (int i = 0; i < H + 3; i++) begin
      @(negedge clk);
      if (!busy) rise_seen = 1;
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("false_busy_idle", rise_seen, 1);
    chk("false_busy_now", busy, 1'b0);
    chk("false_valid", valid, 1'b0);
    wait_cyc(4);

    // Bad stop bit followed by a held-low line
    exp_flag_q.push_back(1);
    send(8'hA5, 1'b0);
    wait_cyc(100);
    @(negedge clk);
    chk("ferr_time", ferr_cyc - t0, 154);
    chk("break_busy", busy, 1'b1);
    chk("break_valid", valid, 1'b0);
    @(posedge clk); #1;
    rxd = 1'b1;
    wait_cyc(3);
    @(negedge clk);
    chk("break_busy_hold", busy, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("break_busy_drop", busy, 1'b0);
    wait_cyc(4);

    // Overrun: two bytes back-to-back with READY low
    exp_byte_q.push_back(8'h12);
    exp_flag_q.push_back(2);
    send(8'h12, 1'b1);
    send(8'h34, 1'b1);
    rxd = 1'b1;
    wait_cyc(4);
    @(negedge clk);
    chk("ovr_time", ovr_cyc - t0, 154);
    chk("ovr_data", data, 8'h12);
    chk("ovr_valid", valid, 1'b1);
    @(posedge clk); #1;
    ready = 1'b1;
    wait_cyc(1);
    ready = 1'b0;
    wait_cyc(4);

    // Stream with READY held high
    ready = 1'b1;
    exp_byte_q.push_back(8'h00);
    exp_byte_q.push_back(8'hFF);
    exp_byte_q.push_back(8'h3C);
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h3C, 1'b1);
    rxd = 1'b1;
    wait_cyc(4);
    @(negedge clk);
    chk("stream_drained", exp_byte_q.size(), 0);
    chk("stream_valid", valid, 1'b0);
    ready = 1'b0;
    wait_cyc(2);

    // Reset in the middle of 0x7E, then a clean 0x81
    rxd = 1'b0;
    wait_cyc(N);
    rxd = 1'b0;
    wait_cyc(N);
    rxd = 1'b1;
    wait_cyc(N / 2);
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    rxd = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", valid, 1'b0);
    wait_cyc(32);
    exp_byte_q.push_back(8'h81);
    send(8'h81, 1'b1);
    rxd = 1'b1;
    wait_cyc(4);
    @(negedge clk);
    chk("data_81", data, 8'h81);
    chk("valid_81", valid, 1'b1);
    chk("lat_81", val_cyc - t0, 154);
    @(posedge clk); #1;
    ready = 1'b1;
    wait_cyc(1);
    ready = 1'b0;
    wait_cyc(4);

    chk("bytes_left", exp_byte_q.size(), 0);
    chk("flags_left", exp_flag_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
